// File: rtl/seq_alu_if.sv
// seq_alu_if: valid/ready operand port and result port of the sequential ALU.
// master = producer of operands / consumer of results; slave = the ALU itself.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out1;
  logic [3:0]       flags;

  modport master (
    output in_valid, opcode, in1, in2, out_ready,
    input  in_ready, out_valid, out1, flags
  );

  modport slave (
    input  in_valid, opcode, in1, in2, out_ready,
    output in_ready, out_valid, out1, flags
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with registered result and NZCV flags {N,Z,C,V}.
// Opcodes 0-6 complete one edge after accept. Defining SEQ_ALU_MUL_EN builds an
// iterative shift-add multiply for opcode 7 (WIDTH+1 edges); otherwise opcode 7
// returns 0 with only Z set after one edge.
module seq_alu #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst,
  seq_alu_if.slave bus
);

`ifdef SEQ_ALU_MUL_EN
  localparam int unsigned CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {StIdle = 2'd0, StBusy = 2'd1, StDone = 2'd2} state_e;
`else
  typedef enum logic [1:0] {StIdle = 2'd0, StDone = 2'd2} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out1_q, out1_d;
  logic [3:0]       flags_q, flags_d;
  logic             accept;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [3:0]       alu_flags;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [2*WIDTH-1:0] shl;

`ifdef SEQ_ALU_MUL_EN
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] step_acc;
`endif

  // In DONE a new operation can be taken in the same cycle as the handoff.
  assign bus.in_ready  = (state_q == StIdle) || ((state_q == StDone) && bus.out_ready);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out1      = out1_q;
  assign bus.flags     = flags_q;
  assign accept        = bus.in_valid && bus.in_ready;

  // Single-cycle datapath for opcodes 0-6 (and the stub opcode 7).
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    sum     = {1'b0, bus.in1} + {1'b0, bus.in2};
    diff    = {1'b0, bus.in1} - {1'b0, bus.in2};
    // Widened shift: bit WIDTH holds the last bit shifted out (0 for amount 0).
    shl     = {{WIDTH{1'b0}}, bus.in1} << bus.in2[SHW-1:0];
    unique case (bus.opcode)
      3'd0: alu_res = bus.in1;
      3'd1: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (bus.in1[WIDTH-1] == bus.in2[WIDTH-1]) &&
                  (sum[WIDTH-1] != bus.in1[WIDTH-1]);
      end
      3'd2: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (bus.in1[WIDTH-1] != bus.in2[WIDTH-1]) &&
                  (diff[WIDTH-1] != bus.in1[WIDTH-1]);
      end
      3'd3: alu_res = bus.in1 & bus.in2;
      3'd4: alu_res = bus.in1 | bus.in2;
      3'd5: alu_res = bus.in1 ^ bus.in2;
      3'd6: begin
        alu_res = shl[WIDTH-1:0];
        alu_c   = shl[WIDTH];
      end
      3'd7: alu_res = '0;
    endcase
    alu_flags = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
  end

  // Next-state, result capture and multiply stepping.
  always_comb begin
    state_d  = state_q;
    out1_d   = out1_q;
    flags_d  = flags_q;
`ifdef SEQ_ALU_MUL_EN
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    step_acc = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d = StDone;
          out1_d  = alu_res;
          flags_d = alu_flags;
`ifdef SEQ_ALU_MUL_EN
          if (bus.opcode == 3'd7) begin
            state_d  = StBusy;
            out1_d   = out1_q;
            flags_d  = flags_q;
            cnt_d    = CW'(WIDTH);
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, bus.in1};
            mplier_d = bus.in2;
          end
`endif
        end else if ((state_q == StIdle) || bus.out_ready) begin
          state_d = StIdle;
        end
      end
`ifdef SEQ_ALU_MUL_EN
      StBusy: begin
        acc_d    = step_acc;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        // Last of WIDTH steps: step_acc now holds the full product.
        if (cnt_q == CW'(1)) begin
          state_d = StDone;
          out1_d  = step_acc[WIDTH-1:0];
          flags_d = {step_acc[WIDTH-1], (step_acc[WIDTH-1:0] == '0),
                     (step_acc[2*WIDTH-1:WIDTH] != '0), 1'b0};
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // State and result registers; reset discards any pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      out1_q   <= '0;
      flags_q  <= '0;
`ifdef SEQ_ALU_MUL_EN
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      out1_q   <= out1_d;
      flags_q  <= flags_d;
`ifdef SEQ_ALU_MUL_EN
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: vector table, randomized ops against an arithmetic reference
// model, plus hand sequences for backpressure, back-to-back and reset.
module tb_seq_alu;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W)) bus ();
  seq_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic [3:0]   f;
    int           lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model from the arithmetic definition of each opcode.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] r,
                                output logic [3:0] f, output int lat);
    longint m, ua, ub, sa, sb, ss, full;
    int amt;
    logic c, v;
    m = longint'(1) << W;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    c = 1'b0;
    v = 1'b0;
    full = 0;
    lat = 1;
    case (op)
      3'd0: full = ua;
      3'd1: begin
        full = ua + ub;
        c = (full >= m);
        ss = sa + sb;
        v = (ss > m / 2 - 1) || (ss < -(m / 2));
      end
      3'd2: begin
        full = ua - ub + m;
        c = (ua < ub);
        ss = sa - sb;
        v = (ss > m / 2 - 1) || (ss < -(m / 2));
      end
      3'd3: full = ua & ub;
      3'd4: full = ua | ub;
      3'd5: full = ua ^ ub;
      3'd6: begin
        amt = int'(ub % W);
        full = ua << amt;
        c = (amt != 0) && (((full >> W) & 1) != 0);
      end
      default: begin
`ifdef SEQ_ALU_MUL_EN
        full = ua * ub;
        c = ((full >> W) != 0);
        lat = W + 1;
`else
        full = 0;
`endif
      end
    endcase
    r = W'(full % m);
    f = {r[W-1], (r == '0), c, v};
  endfunction

  // Starts at edge+1 with the DUT idle; ends at edge+1 after the handoff.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, output logic [W-1:0] r, output logic [3:0] f,
                        output int lat);
    logic [W-1:0] r0;
    logic [3:0] f0;
    bus.in_valid = 1'b1;
    bus.opcode = op;
    bus.in1 = a;
    bus.in2 = b;
    bus.out_ready = (hold == 0);
    #1;
    chk("accept_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    // Scramble sources: the block must have latched its operands.
    bus.in_valid = 1'b0;
    bus.opcode = 3'($urandom);
    bus.in1 = W'($urandom);
    bus.in2 = W'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    r0 = bus.out1;
    f0 = bus.flags;
    for (int i = 0; i < hold; i++) begin
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_out1", 32'(bus.out1), 32'(r0));
      chk("hold_flags", 32'(bus.flags), 32'(f0));
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    chk("done_in_ready", 32'(bus.in_ready), 32'd1);
    r = bus.out1;
    f = bus.flags;
    @(posedge clk); #1;
    chk("after_handoff_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] r, er;
    logic [3:0] f, ef;
    int lat, elat;
    logic [2:0] bop[4];
    logic [W-1:0] ba[4], bb[4], br[4];
    logic [3:0] bf[4];

    vecs[0]  = '{3'd1, 8'hFF, 8'h01, 8'h00, 4'b0110, 1};
    vecs[1]  = '{3'd2, 8'h80, 8'h01, 8'h7F, 4'b0001, 1};
    vecs[2]  = '{3'd2, 8'h01, 8'h02, 8'hFF, 4'b1010, 1};
    vecs[3]  = '{3'd3, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1};
    vecs[4]  = '{3'd4, 8'h00, 8'h00, 8'h00, 4'b0100, 1};
    vecs[5]  = '{3'd5, 8'hAA, 8'hFF, 8'h55, 4'b0000, 1};
    vecs[6]  = '{3'd0, 8'h80, 8'h12, 8'h80, 4'b1000, 1};
    vecs[7]  = '{3'd1, 8'h7F, 8'h01, 8'h80, 4'b1001, 1};
    vecs[8]  = '{3'd6, 8'h81, 8'h01, 8'h02, 4'b0010, 1};
    vecs[9]  = '{3'd6, 8'h81, 8'h00, 8'h81, 4'b1000, 1};
    vecs[10] = '{3'd6, 8'h03, 8'h07, 8'h80, 4'b1010, 1};
    vecs[11] = '{3'd2, 8'h05, 8'h05, 8'h00, 4'b0100, 1};
`ifdef SEQ_ALU_MUL_EN
    vecs[12] = '{3'd7, 8'd15, 8'd17, 8'hFF, 4'b1000, W + 1};
    vecs[13] = '{3'd7, 8'd16, 8'd16, 8'h00, 4'b0110, W + 1};
`else
    vecs[12] = '{3'd7, 8'd15, 8'd17, 8'h00, 4'b0100, 1};
    vecs[13] = '{3'd7, 8'd16, 8'd16, 8'h00, 4'b0100, 1};
`endif

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.opcode = '0;
    bus.in1 = '0;
    bus.in2 = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out1", 32'(bus.out1), 32'd0);
    chk("reset_flags", 32'(bus.flags), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vector table.
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, r, f, lat);
      chk($sformatf("vec%0d_out1", i), 32'(r), 32'(vecs[i].r));
      chk($sformatf("vec%0d_flags", i), 32'(f), 32'(vecs[i].f));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Backpressure: SHL 0x81 by 1 held for 5 cycles.
    run_op(3'd6, 8'h81, 8'h01, 5, r, f, lat);
    chk("bp_out1", 32'(r), 32'h02);
    chk("bp_flags", 32'(f), 32'b0010);

    // Back-to-back ADD/AND/OR/XOR with out_ready held high.
    bop[0] = 3'd1; ba[0] = 8'h10; bb[0] = 8'h20;
    bop[1] = 3'd3; ba[1] = 8'hF0; bb[1] = 8'h0F;
    bop[2] = 3'd4; ba[2] = 8'hF0; bb[2] = 8'h0F;
    bop[3] = 3'd5; ba[3] = 8'hFF; bb[3] = 8'hFF;
    for (int i = 0; i < 4; i++) model(bop[i], ba[i], bb[i], br[i], bf[i], elat);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.opcode = bop[i];
      bus.in1 = ba[i];
      bus.in2 = bb[i];
      #1;
      chk($sformatf("b2b%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      if (i > 0) begin
        chk($sformatf("b2b%0d_valid", i - 1), 32'(bus.out_valid), 32'd1);
        chk($sformatf("b2b%0d_out1", i - 1), 32'(bus.out1), 32'(br[i-1]));
        chk($sformatf("b2b%0d_flags", i - 1), 32'(bus.flags), 32'(bf[i-1]));
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    #1;
    chk("b2b3_valid", 32'(bus.out_valid), 32'd1);
    chk("b2b3_out1", 32'(bus.out1), 32'(br[3]));
    chk("b2b3_flags", 32'(bus.flags), 32'(bf[3]));
    @(posedge clk); #1;
    chk("b2b_end_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // Reset while holding a result in DONE.
    bus.in_valid = 1'b1;
    bus.opcode = 3'd0;
    bus.in1 = 8'h5A;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("rdone_valid_before", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rdone_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rdone_out1", 32'(bus.out1), 32'd0);
    chk("rdone_flags", 32'(bus.flags), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rdone_in_ready", 32'(bus.in_ready), 32'd1);

`ifdef SEQ_ALU_MUL_EN
    // Reset at cycle 4 of a MUL: no result may appear afterwards.
    run_op(3'd0, 8'hA5, 8'h00, 0, r, f, lat);
    bus.in_valid = 1'b1;
    bus.opcode = 3'd7;
    bus.in1 = 8'd15;
    bus.in2 = 8'd17;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rmul_busy_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("rmul_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rmul_out1", 32'(bus.out1), 32'd0);
    chk("rmul_flags", 32'(bus.flags), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rmul_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      chk("rmul_no_result", 32'(bus.out_valid), 32'd0);
    end
    bus.out_ready = 1'b0;
`endif

    // Randomized operations with random backpressure.
    for (int n = 0; n < 150; n++) begin
      logic [2:0] op;
      logic [W-1:0] a, b;
      int hold;
      op = 3'($urandom_range(0, 7));
      a = W'($urandom);
      b = W'($urandom);
      hold = $urandom_range(0, 2);
      model(op, a, b, er, ef, elat);
      run_op(op, a, b, hold, r, f, lat);
      chk($sformatf("rnd%0d_op%0d_out1", n, op), 32'(r), 32'(er));
      chk($sformatf("rnd%0d_op%0d_flags", n, op), 32'(f), 32'(ef));
      chk($sformatf("rnd%0d_op%0d_latency", n, op), 32'(lat), 32'(elat));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the single-cycle 8-bit ALU. It takes two WIDTH-bit operands and a 3-bit opcode through a valid/ready input port and returns a registered result plus NZCV flags through a valid/ready output port. Most operations take one cycle. An optional iterative shift-add multiply takes several cycles. The block sits between the register-file read stage and writeback, and it holds its result until the consumer accepts it.

## Interface
- WIDTH, 8: operand and result width. Must be a power of 2 and at least 4.
- SHW, $clog2(WIDTH): width of the shift-amount field taken from in2[SHW-1:0].

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands and opcode are presented
- in_ready  out  1  block can accept this cycle (combinational)
- opcode  in  3  operation select
- in1  in  WIDTH  operand A
- in2  in  WIDTH  operand B
- out_valid  out  1  out1 and flags are valid
- out_ready  in  1  consumer accepts the result
- out1  out  WIDTH  result
- flags  out  4  {N,Z,C,V} as flags[3]=N, flags[2]=Z, flags[1]=C, flags[0]=V

## Operation
- Opcodes:
  - 0 PASS: result = in1.
  - 1 ADD: in1+in2. C = carry out; V = signed overflow.
  - 2 SUB: in1-in2. C = borrow, i.e. in1<in2 unsigned; V = signed overflow.
  - 3 AND, 4 OR, 5 XOR: C=0, V=0.
  - 6 SHL: in1 << in2[SHW-1:0]. C = last bit shifted out, or 0 when the shift amount is 0; V=0.
  - 7 MUL: low WIDTH bits of in1*in2 (unsigned). C=1 if the upper WIDTH bits of the product are nonzero; V=0.
- N = result[WIDTH-1] and Z = (result==0) for every opcode.
- All arithmetic is modulo 2^WIDTH. Operands are latched on accept, so the source may change them afterwards.
- FSM states:
  - IDLE: in_ready=1.
    - Accept of opcode 0-6 → DONE.
    - Accept of MUL → BUSY, with the counter loaded to WIDTH.
  - BUSY: in_ready=0. One shift-add step per cycle. The counter decrements; at 0 the block writes out1/flags and goes to DONE.
  - DONE: out_valid=1, and out1/flags are held stable.
    - out_ready=0: stay in DONE.
    - out_ready=1 with no new accept: → IDLE.
    - out_ready=1 with in_valid=1: the new operation is accepted in the same cycle (in_ready = out_ready in DONE) and the next state follows the IDLE rules.
- Accept is the cycle with in_valid && in_ready. Handoff is the cycle with out_valid && out_ready.
- in_valid while in_ready=0 is ignored. The source must hold its request.

## Timing
- Reset values: out_valid=0, out1=0, flags=4'b0000, state=IDLE, counter=0. in_ready reads 1 while in reset.
- Latency for opcodes 0-6: out_valid rises on the edge after accept (1 cycle).
- Latency for MUL: out_valid rises WIDTH+1 edges after accept (9 for WIDTH=8).
- Throughput:
  - One result per cycle for opcodes 0-6 when out_ready is held at 1.
  - MUL blocks new input for WIDTH+1 cycles.
- Reset asserted during BUSY or DONE:
  - out_valid drops immediately (asynchronous).
  - The pending result is discarded.
  - After release the block is in IDLE.
- out_ready while out_valid=0 has no effect.

## Configuration
- SEQ_ALU_MUL_EN defined:
  - Opcode 7 is the iterative multiply, with the BUSY state and counter.
- SEQ_ALU_MUL_EN undefined:
  - The BUSY state and multiply datapath are not built.
  - Opcode 7 completes in 1 cycle with out1=0 and flags=4'b0100 (Z only).

## Test plan
All scenarios use WIDTH=8.
- ADD in1=8'hFF, in2=8'h01, out_ready=1 → one cycle after accept: out1=8'h00, flags=4'b0110 (Z,C), out_valid high for 1 cycle.
- SUB in1=8'h80, in2=8'h01 → out1=8'h7F, flags=4'b0001 (V). SUB 8'h01-8'h02 → out1=8'hFF, flags=4'b1010 (N,C).
- With SEQ_ALU_MUL_EN:
  - MUL 8'd15*8'd17 → out1=8'hFF, flags=4'b1000, out_valid 9 cycles after accept, in_ready=0 throughout.
  - MUL 8'd16*8'd16 → out1=8'h00, flags=4'b0110.
  - Without the macro, opcode 7 → out1=0, flags=4'b0100 after 1 cycle.
- Backpressure: SHL in1=8'h81, in2=1, out_ready=0 for 5 cycles → out1=8'h02 and flags=4'b0010 stable, out_valid=1, in_ready=0. The handoff occurs on the first cycle out_ready=1.
- Back-to-back: 4 consecutive accepts of ADD/AND/OR/XOR with in_valid=1 and out_ready=1 → 4 results on 4 consecutive cycles, in order, with in_ready=1 throughout.
- Assert rst for 1 cycle at cycle 4 of a MUL → out_valid=0, flags=0 and out1=0 immediately. No result is produced, and in_ready=1 after release.
